// File: rtl/rxuart_cfg_if.sv
// Receive-side handshake bundle for rxuart_cfg: held character, status flags and consumer ready.
interface rxuart_cfg_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 o_valid;
    logic                 i_ready;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_overrun;
    logic                 o_break;

    modport master (
        output o_valid, o_data, o_frame_err, o_parity_err, o_overrun, o_break,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_data, o_frame_err, o_parity_err, o_overrun, o_break,
        output i_ready
    );
endinterface

// File: rtl/rxuart_cfg.sv
// Configurable UART receiver: runtime baud divisor, optional parity, 1-2 stop bits,
// break detection and a single-entry valid/ready output buffer with overrun flag.
module rxuart_cfg #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned BAUD_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_uart_rx,
    input  logic [BAUD_W-1:0] i_clocks_per_baud,
    rxuart_cfg_if.master      rx_if
);
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreakWait
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic [BAUD_W-1:0]    div_q, div_d, cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
    logic                 ovr_q, ovr_d, brk_q, brk_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    logic              tick, deliver, is_break, new_ferr, new_perr, ones, accept;
    logic [BAUD_W-1:0] div_clamp;

    always_comb begin
        state_d    = state_q;
        rx_meta_d  = i_uart_rx;
        rx_sync_d  = rx_meta_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop_cnt_d = stop_cnt_q;
        ferr_acc_d = ferr_acc_q;
        brk_d      = 1'b0;
        deliver    = 1'b0;
        new_ferr   = ferr_acc_q;

        tick      = (cnt_q == '0);
        div_clamp = (i_clocks_per_baud < BAUD_W'(4)) ? BAUD_W'(4) : i_clocks_per_baud;
        is_break  = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !rx_sync_q;
        ones      = (^shift_q) ^ par_bit_q;
        new_perr  = (PARITY == 1) ? ~ones : (PARITY == 2) ? ones : 1'b0;

        if (state_q != StIdle && !tick) cnt_d = cnt_q - BAUD_W'(1);

        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    // Divisor is frozen here for the whole frame.
                    div_d   = div_clamp;
                    cnt_d   = (div_clamp >> 1) - BAUD_W'(1);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rx_sync_q) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d     = div_q - BAUD_W'(1);
                        bit_cnt_d = 4'd0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = div_q - BAUD_W'(1);
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d    = (PARITY != 0) ? StParity : StStop;
                        stop_cnt_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    par_bit_d = rx_sync_q;
                    cnt_d     = div_q - BAUD_W'(1);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    if (!stop_cnt_q && is_break) begin
                        brk_d   = 1'b1;
                        state_d = StBreakWait;
                    end else if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        deliver  = 1'b1;
                        new_ferr = ferr_acc_q | ~rx_sync_q;
                        state_d  = StIdle;
                    end else begin
                        ferr_acc_d = ferr_acc_q | ~rx_sync_q;
                        stop_cnt_d = 1'b1;
                        cnt_d      = div_q - BAUD_W'(1);
                    end
                end
            end
            StBreakWait: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output buffer: an accept in the same cycle frees the slot for a new character.
    always_comb begin
        accept  = valid_q && rx_if.i_ready;
        valid_d = valid_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (deliver && (!valid_q || accept)) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            ferr_d  = new_ferr;
            perr_d  = new_perr;
            ovr_d   = 1'b0;
        end else if (deliver) begin
            ovr_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_cnt_q <= stop_cnt_d;
            ferr_acc_q <= ferr_acc_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign rx_if.o_valid      = valid_q;
    assign rx_if.o_data       = data_q;
    assign rx_if.o_frame_err  = ferr_q;
    assign rx_if.o_parity_err = perr_q;
    assign rx_if.o_overrun    = ovr_q;
    assign rx_if.o_break      = brk_q;
endmodule

// File: tb/tb_rxuart_cfg.sv
// Directed bench for rxuart_cfg: an 8N1 instance (a) and an 8E1 instance (b) on a shared clock.
module tb_rxuart_cfg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_a, rx_b;
    logic [15:0] cpb;
    int          total = 0;
    int          bad = 0;
    int          nvalid_a = 0;
    int          nbrk_a = 0;
    logic        prev_valid_a = 1'b0;

    rxuart_cfg_if #(.DATA_BITS(8)) if_a ();
    rxuart_cfg_if #(.DATA_BITS(8)) if_b ();

    rxuart_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_W(16)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx_a), .i_clocks_per_baud(cpb), .rx_if(if_a)
    );
    rxuart_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .BAUD_W(16)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx_b), .i_clocks_per_baud(cpb), .rx_if(if_b)
    );

    always #5 clk = ~clk;

    // Count new deliveries and break pulses on instance a.
    always @(posedge clk) begin
        prev_valid_a <= if_a.o_valid;
        if (if_a.o_valid && !prev_valid_a) nvalid_a <= nvalid_a + 1;
        if (if_a.o_break) nbrk_a <= nbrk_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive n bits LSB-first, each held d clocks, then idle the line high.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int d);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx_a = bits[i];
            else          rx_b = bits[i];
            cycles(d);
        end
        if (sel == 0) rx_a = 1'b1;
        else          rx_b = 1'b1;
    endtask

    task automatic send8n1(input logic [7:0] data, input int d);
        send_bits(0, {6'h3f, 1'b1, data, 1'b0}, 10, d);
    endtask

    task automatic accept_a();
        if_a.i_ready = 1'b1;
        cycles(1);
        if_a.i_ready = 1'b0;
    endtask

    int nv;

    initial begin
        rst_n = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        cpb = 16'd16;
        if_a.i_ready = 1'b0;
        if_b.i_ready = 1'b0;
        cycles(3);
        check("rst_valid", {31'd0, if_a.o_valid}, 0);
        check("rst_data", {24'd0, if_a.o_data}, 0);
        check("rst_flags", {28'd0, if_a.o_frame_err, if_a.o_parity_err, if_a.o_overrun,
                            if_a.o_break}, 0);
        rst_n = 1'b1;
        cycles(4);

        // Basic 8N1 character and handshake.
        send8n1(8'h41, 16);
        cycles(2);
        check("c41_valid", {31'd0, if_a.o_valid}, 1);
        check("c41_data", {24'd0, if_a.o_data}, 32'h41);
        check("c41_flags", {29'd0, if_a.o_frame_err, if_a.o_parity_err, if_a.o_overrun}, 0);
        cycles(5);
        check("c41_hold", {31'd0, if_a.o_valid}, 1);
        accept_a();
        check("c41_clear", {31'd0, if_a.o_valid}, 0);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right.
        send_bits(1, {4'hf, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 16);
        cycles(2);
        check("par1_data", {24'd0, if_b.o_data}, 32'h03);
        check("par1_err", {31'd0, if_b.o_parity_err}, 1);
        if_b.i_ready = 1'b1;
        cycles(1);
        if_b.i_ready = 1'b0;
        send_bits(1, {4'hf, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 16);
        cycles(2);
        check("par0_valid", {31'd0, if_b.o_valid}, 1);
        check("par0_err", {31'd0, if_b.o_parity_err}, 0);

        // Stop bit low on a nonzero character: delivered with frame error.
        send_bits(0, {6'h3f, 1'b0, 8'h41, 1'b0}, 10, 16);
        cycles(20);
        check("ferr_data", {24'd0, if_a.o_data}, 32'h41);
        check("ferr_flag", {31'd0, if_a.o_frame_err}, 1);
        accept_a();

        // Start-bit glitch is rejected.
        nv = nvalid_a;
        rx_a = 1'b0;
        cycles(4);
        rx_a = 1'b1;
        cycles(32);
        check("glitch_nv", nvalid_a, nv);
        check("glitch_state", {29'd0, dut_a.state_q}, 0);
        send8n1(8'h55, 16);
        cycles(2);
        check("c55_data", {24'd0, if_a.o_data}, 32'h55);
        check("c55_ferr", {31'd0, if_a.o_frame_err}, 0);
        accept_a();

        // Overrun: second character dropped while first is held.
        send8n1(8'h11, 16);
        send8n1(8'h22, 16);
        cycles(2);
        check("ovr_valid", {31'd0, if_a.o_valid}, 1);
        check("ovr_data", {24'd0, if_a.o_data}, 32'h11);
        check("ovr_flag", {31'd0, if_a.o_overrun}, 1);
        accept_a();
        check("ovr_vclr", {31'd0, if_a.o_valid}, 0);
        check("ovr_oclr", {31'd0, if_a.o_overrun}, 0);

        // Break: line low for 20 bit times.
        nv = nvalid_a;
        rx_a = 1'b0;
        cycles(20 * 16);
        rx_a = 1'b1;
        cycles(8);
        check("brk_pulses", nbrk_a, 1);
        check("brk_nv", nvalid_a, nv);
        check("brk_valid", {31'd0, if_a.o_valid}, 0);
        send8n1(8'hA5, 16);
        cycles(2);
        check("cA5_data", {24'd0, if_a.o_data}, 32'hA5);
        accept_a();

        // Divisor change mid-frame applies only from the next start bit.
        fork
            send8n1(8'h5A, 16);
            begin
                cycles(50);
                cpb = 16'd32;
            end
        join
        cycles(2);
        check("d16_data", {24'd0, if_a.o_data}, 32'h5A);
        check("d16_valid", {31'd0, if_a.o_valid}, 1);
        accept_a();
        send8n1(8'h5A, 32);
        cycles(2);
        check("d32_data", {24'd0, if_a.o_data}, 32'h5A);
        check("d32_valid", {31'd0, if_a.o_valid}, 1);
        accept_a();

        // Reset in the middle of a frame abandons it.
        nv = nvalid_a;
        send_bits(0, {6'h3f, 1'b1, 8'h5A, 1'b0}, 5, 32);
        rx_a = 1'b0;
        rst_n = 1'b0;
        cycles(2);
        rx_a = 1'b1;
        rst_n = 1'b1;
        cycles(3 * 32 * 4);
        check("rstmid_nv", nvalid_a, nv);
        check("rstmid_valid", {31'd0, if_a.o_valid}, 0);
        check("rstmid_flags", {28'd0, if_a.o_frame_err, if_a.o_parity_err, if_a.o_overrun,
                               if_a.o_break}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rxuart_cfg.md
RXUART_CFG -- requirements
Module: rxuart_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per character (legal 5..8).
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked (legal 1..2).
REQ-004 SHALL have parameter BAUD_W, default 16, width of the baud divisor.
REQ-005 i_clk  input  1  sole clock, all logic on posedge.
REQ-006 i_reset_n  input  1  reset, synchronous and active-low.
REQ-007 i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-008 i_clocks_per_baud  input  BAUD_W  clocks per bit period, runtime.
REQ-009 o_valid  output  1  received character held in o_data.
REQ-010 i_ready  input  1  consumer accepts character.
REQ-011 o_data  output  DATA_BITS  received character, LSB = first bit on wire.
REQ-012 o_frame_err  output  1  stop bit sampled low for held character.
REQ-013 o_parity_err  output  1  parity mismatch for held character (0 when PARITY=0).
REQ-014 o_overrun  output  1  at least one character dropped since last accept.
REQ-015 o_break  output  1  one-cycle pulse on break detection.

Function
REQ-016 SHALL pass i_uart_rx through a 2-FF synchroniser; all sampling uses the synchronised line.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-018 IDLE: on synchronised line low, latch divisor D = max(i_clocks_per_baud, 4), load counter D/2-1, enter START.
REQ-019 Divisor SHALL be held constant for the whole frame; i_clocks_per_baud changes mid-frame take effect on next start.
REQ-020 START at counter 0: line high -> glitch, return to IDLE, no output; line low -> load D-1, enter DATA.
REQ-021 DATA: sample at each counter 0, shift in LSB-first, reload D-1; after DATA_BITS samples go PARITY (PARITY!=0) else STOP.
REQ-022 PARITY: sample one bit; odd mode error if ones(data+bit) even; even mode error if odd.
REQ-023 STOP: sample STOP_BITS bits at D intervals; any low sample sets frame error for the character.
REQ-024 Break: data all zero, parity bit (if any) zero, and first stop bit low -> pulse o_break 1 cycle, deliver no character, enter BREAK_WAIT.
REQ-025 BREAK_WAIT: remain until synchronised line high, then IDLE.
REQ-026 Non-break frame: after final stop sample, return to IDLE the same cycle (back-to-back frames supported) and deliver the character.
REQ-027 Delivery: o_valid, o_data, o_frame_err, o_parity_err update in the cycle after the final stop sample.
REQ-028 Handshake: o_valid clears the cycle after o_valid && i_ready; o_data and flags stable while o_valid && !i_ready.
REQ-029 Delivery while o_valid && !i_ready: new character dropped, held character unchanged, o_overrun set.
REQ-030 Delivery in the same cycle as accept: new character loads, o_valid stays 1, no overrun.
REQ-031 o_overrun SHALL stay set until the next accept and then clear.
REQ-032 Frame-error characters SHALL still be delivered, with o_frame_err=1.

Reset
REQ-033 i_reset_n low at a clock edge: state IDLE, synchroniser FFs 1, counter 0, o_valid 0, o_data 0, all flags 0, o_break 0.
REQ-034 Reset mid-frame SHALL abandon the frame with no delivery and no flag.
REQ-035 Reset SHALL override simultaneous delivery or handshake events.

Verification
REQ-036 D=16, 8N1, send 0x41 -> o_valid=1, o_data=0x41, all flags 0; holds until i_ready; clears next cycle.
REQ-037 PARITY=2, send 0x03 with parity bit 1 -> o_data=0x03, o_parity_err=1; with parity bit 0 -> o_parity_err=0.
REQ-038 Line low 4 clocks then high, D=16 -> no o_valid, state returns to IDLE; following 0x55 received correctly.
REQ-039 i_ready=0, send 0x11 then 0x22 -> o_data=0x11, o_overrun=1; raise i_ready -> o_valid clears and o_overrun clears.
REQ-040 Line held low 20 bit times -> one o_break pulse, no o_valid; after line high, 0xA5 received.
REQ-041 Send 0x5A at D=16, then set D=32 mid-frame and send 0x5A at D=32 -> both received correctly; reset mid-frame -> no o_valid.
